dcpu16_busarb: RTL and testbench



---
 rtl/dcpu16_busarb_pkg.sv | 24 ++
 rtl/dcpu16_busarb_port.sv | 43 ++++
 rtl/dcpu16_busarb.sv | 187 ++++++++++++++++++
 tb/tb_dcpu16_busarb.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu16_busarb_pkg.sv
// Shared definitions for the DCPU16 memory-side bus arbiter: FSM encoding,
// port select values and the stall/advance rule also used by the memory bus unit.
package dcpu16_busarb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSF = 2'd1,
    BUSG = 2'd2
  } arb_state_t;

  typedef enum logic {
    SEL_F = 1'b0,
    SEL_G = 1'b1
  } port_sel_t;

  localparam int NUM_PORTS = 2;

  // The pipeline moves on when every strobe has been answered (or none is raised).
  function automatic logic bus_adv(input logic g_stb, input logic g_ack,
                                   input logic f_stb, input logic f_ack);
    return (g_stb ~^ g_ack) & (f_stb ~^ f_ack);
  endfunction

endpackage

// File: rtl/dcpu16_busarb_port.sv
// Per-port completion tracking: done flag, read-data register and ack generation.
module dcpu16_busarb_port
  import dcpu16_busarb_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stb,
  input  logic          adv,
  input  logic          complete,
  input  logic          rd,
  input  logic [DW-1:0] rdata,
  output logic          ack,
  output logic          done,
  output logic [DW-1:0] dti
);

  logic          done_reg;
  logic [DW-1:0] dti_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_reg <= 1'b0;
      dti_reg  <= '0;
    end else begin
      // A completion whose strobe was withdrawn is dropped: no done, no data.
      if (adv) begin
        done_reg <= 1'b0;
      end else if (complete && stb) begin
        done_reg <= 1'b1;
      end
      if (complete && stb && rd) begin
        dti_reg <= rdata;
      end
    end
  end

  assign ack  = done_reg & stb;
  assign done = done_reg;
  assign dti  = dti_reg;

endmodule

// File: rtl/dcpu16_busarb.sv
// Serialises G-bus and F-bus requests onto one Wishbone master (F has priority).
// Optional slave timeout enabled by defining DCPU16_BUSARB_TIMEOUT_EN.
module dcpu16_busarb
  import dcpu16_busarb_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int TMO_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] g_adr,
  input  logic          g_stb,
  input  logic          g_wre,
  output logic [DW-1:0] g_dti,
  output logic          g_ack,
  input  logic [AW-1:0] f_adr,
  input  logic          f_stb,
  input  logic          f_wre,
  input  logic [DW-1:0] f_dto,
  output logic [DW-1:0] f_dti,
  output logic          f_ack,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  output logic          wb_we_o,
  output logic          wb_stb_o,
  output logic          wb_cyc_o,
  input  logic          wb_ack_i,
  output logic          wb_err_o
);

  arb_state_t    state_reg;
  logic          wb_stb_reg;
  logic          wb_we_reg;
  logic [AW-1:0] wb_adr_reg;
  logic [DW-1:0] wb_dat_reg;

  logic [NUM_PORTS-1:0] port_stb;
  logic [NUM_PORTS-1:0] port_ack;
  logic [NUM_PORTS-1:0] port_done;
  logic [NUM_PORTS-1:0] port_pend;
  logic [NUM_PORTS-1:0] port_grant;
  logic [NUM_PORTS-1:0] port_complete;
  logic [DW-1:0]        port_dti [NUM_PORTS];

  logic          adv;
  logic          tmo_hit;
  logic          xfer_done;
  logic [DW-1:0] rdata_mux;
  logic          issue_en;
  port_sel_t     issue_sel;

  assign port_stb[SEL_F] = f_stb;
  assign port_stb[SEL_G] = g_stb;

  assign port_grant[SEL_F] = (state_reg == BUSF);
  assign port_grant[SEL_G] = (state_reg == BUSG);

  assign adv       = bus_adv(g_stb, g_ack, f_stb, f_ack);
  assign xfer_done = wb_stb_reg & (wb_ack_i | tmo_hit);
  assign rdata_mux = tmo_hit ? '0 : wb_dat_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_pend[gi]     = port_stb[gi] & ~port_done[gi];
      assign port_complete[gi] = xfer_done & port_grant[gi];

      dcpu16_busarb_port #(
        .DW(DW)
      ) u_port (
        .clk      (clk),
        .rst      (rst),
        .stb      (port_stb[gi]),
        .adv      (adv),
        .complete (port_complete[gi]),
        .rd       (~wb_we_reg),
        .rdata    (rdata_mux),
        .ack      (port_ack[gi]),
        .done     (port_done[gi]),
        .dti      (port_dti[gi])
      );
    end
  endgenerate

  // A bus state with the strobe low is the entry cycle after a back-to-back handover.
  always_comb begin
    issue_en  = 1'b0;
    issue_sel = SEL_F;
    case (state_reg)
      IDLE: begin
        if (port_pend[SEL_F]) begin
          issue_en = 1'b1;
        end else if (port_pend[SEL_G]) begin
          issue_en  = 1'b1;
          issue_sel = SEL_G;
        end
      end
      BUSF: begin
        if (!wb_stb_reg && port_pend[SEL_F]) begin
          issue_en = 1'b1;
        end
      end
      BUSG: begin
        if (!wb_stb_reg && port_pend[SEL_G]) begin
          issue_en  = 1'b1;
          issue_sel = SEL_G;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      wb_stb_reg <= 1'b0;
      wb_we_reg  <= 1'b0;
      wb_adr_reg <= '0;
      wb_dat_reg <= '0;
    end else if (issue_en) begin
      wb_stb_reg <= 1'b1;
      if (issue_sel == SEL_F) begin
        state_reg  <= BUSF;
        wb_adr_reg <= f_adr;
        wb_we_reg  <= f_wre;
        wb_dat_reg <= f_dto;
      end else begin
        state_reg  <= BUSG;
        wb_adr_reg <= g_adr;
        wb_we_reg  <= g_wre;
        wb_dat_reg <= '0;
      end
    end else if (wb_stb_reg) begin
      if (xfer_done) begin
        wb_stb_reg <= 1'b0;
        if (state_reg == BUSF && port_pend[SEL_G]) begin
          state_reg <= BUSG;
        end else if (state_reg == BUSG && port_pend[SEL_F]) begin
          state_reg <= BUSF;
        end else begin
          state_reg <= IDLE;
        end
      end
    end else if (state_reg != IDLE) begin
      state_reg <= IDLE;
    end
  end

`ifdef DCPU16_BUSARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= tmo_hit;
      if (issue_en) begin
        tmo_cnt_reg <= '0;
      end else if (wb_stb_reg && !wb_ack_i) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
    end
  end

  assign tmo_hit  = wb_stb_reg & ~wb_ack_i & (&tmo_cnt_reg);
  assign wb_err_o = err_reg;
`else
  localparam int tmo_w_unused = TMO_W;
  assign tmo_hit  = 1'b0;
  assign wb_err_o = 1'b0;
`endif

  assign g_ack    = port_ack[SEL_G];
  assign f_ack    = port_ack[SEL_F];
  assign g_dti    = port_dti[SEL_G];
  assign f_dti    = port_dti[SEL_F];
  assign wb_stb_o = wb_stb_reg;
  assign wb_cyc_o = wb_stb_reg;
  assign wb_we_o  = wb_we_reg;
  assign wb_adr_o = wb_adr_reg;
  assign wb_dat_o = wb_dat_reg;

endmodule

// File: tb/tb_dcpu16_busarb.sv
// Self-checking bench for dcpu16_busarb: directed scenarios plus randomized
// request groups checked against a transaction-level memory model.
module tb_dcpu16_busarb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] g_adr, f_adr, f_dto, wb_dat_i;
  logic        g_stb, g_wre, f_stb, f_wre;
  logic [15:0] g_dti, f_dti, wb_adr_o, wb_dat_o;
  logic        g_ack, f_ack, wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcpu16_busarb #(.AW(16), .DW(16), .TMO_W(4)) dut (
    .clk(clk), .rst(rst),
    .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dti(g_dti), .g_ack(g_ack),
    .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto), .f_dti(f_dti), .f_ack(f_ack),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_err_o(wb_err_o)
  );

  // Slave memory with programmable wait states and a transaction monitor.
  int          slave_wait = 0;
  logic        slave_noack = 1'b0;
  int          wait_cnt = 0;
  logic [15:0] slave_mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_adr = '0, pre_dat = '0;
  int          mon_cnt = 0;
  logic [15:0] mon_adr [64];
  logic        mon_we  [64];
  logic [15:0] mon_dat [64];

  assign wb_ack_i = wb_stb_o && !slave_noack && (wait_cnt == slave_wait);
  assign wb_dat_i = slave_mem[wb_adr_o];

  always @(posedge clk) begin
    if (pre_we) slave_mem[pre_adr] <= pre_dat;
    else if (wb_stb_o && wb_ack_i && wb_we_o) slave_mem[wb_adr_o] <= wb_dat_o;
    if (!wb_stb_o || wb_ack_i) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (wb_stb_o && wb_ack_i && !rst) begin
      mon_adr[mon_cnt % 64] <= wb_adr_o;
      mon_we[mon_cnt % 64]  <= wb_we_o;
      mon_dat[mon_cnt % 64] <= wb_dat_o;
      mon_cnt <= mon_cnt + 1;
    end
  end

  logic [15:0] ref_mem [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] adr, input logic [15:0] dat);
    pre_adr = adr;
    pre_dat = dat;
    pre_we  = 1'b1;
    tick();
    pre_we  = 1'b0;
  endtask

  task automatic idle_inputs();
    g_adr = '0; g_stb = 0; g_wre = 0;
    f_adr = '0; f_stb = 0; f_wre = 0; f_dto = '0;
  endtask

  task automatic test_reset();
    logic [69:0] outs;
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    outs = {wb_stb_o, wb_cyc_o, wb_we_o, wb_err_o, g_ack, f_ack, wb_adr_o, wb_dat_o, g_dti, f_dti};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_g_read();
    slave_wait = 0;
    preload(16'h0010, 16'h7C01);
    tick();
    g_adr = 16'h0010; g_stb = 1'b1; g_wre = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_stb_o !== 1'b0 || g_ack !== 1'b0) begin
      errors++; $display("FAIL g_read_n: stb=%b ack=%b expected 0 0", wb_stb_o, g_ack);
    end
    @(negedge clk);
    checks++;
    if ({wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, g_ack} !== {3'b110, 16'h0010, 1'b0}) begin
      errors++;
      $display("FAIL g_read_bus: stb=%b cyc=%b we=%b adr=%h ack=%b expected 1 1 0 0010 0",
               wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, g_ack);
    end
    @(negedge clk);
    checks++;
    if (g_ack !== 1'b1 || g_dti !== 16'h7C01) begin
      errors++; $display("FAIL g_read_ack: ack=%b dti=%h expected 1 7c01", g_ack, g_dti);
    end
    tick();
    g_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (g_ack !== 1'b0 || g_dti !== 16'h7C01 || wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL g_read_after_adv: ack=%b dti=%h stb=%b expected 0 7c01 0", g_ack, g_dti, wb_stb_o);
    end
    $display("txn g_read adr=0010 dti=%h", g_dti);
  endtask

  task automatic test_f_write();
    slave_wait = 3;
    tick();
    f_adr = 16'hFFFF; f_dto = 16'h1234; f_wre = 1'b1; f_stb = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if ({wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, f_ack, wb_ack_i} !==
          {2'b11, 16'hFFFF, 16'h1234, 1'b0, (i == 4)}) begin
        errors++;
        $display("FAIL f_write_hold%0d: stb=%b we=%b adr=%h dat=%h ack=%b slave_ack=%b expected 1 1 ffff 1234 0 %0d",
                 i, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, f_ack, wb_ack_i, (i == 4));
      end
    end
    @(negedge clk);
    checks++;
    if (f_ack !== 1'b1 || wb_stb_o !== 1'b0) begin
      errors++; $display("FAIL f_write_ack: ack=%b stb=%b expected 1 0", f_ack, wb_stb_o);
    end
    tick();
    f_stb = 1'b0; f_wre = 1'b0;
    $display("txn f_write adr=ffff dat=1234");
  endtask

  task automatic test_simultaneous();
    slave_wait = 0;
    preload(16'h0200, 16'hABCD);
    tick();
    f_adr = 16'h0100; f_dto = 16'h5555; f_wre = 1'b1; f_stb = 1'b1;
    g_adr = 16'h0200; g_wre = 1'b0; g_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({wb_stb_o, wb_we_o, wb_adr_o} !== {2'b11, 16'h0100}) begin
      errors++; $display("FAIL sim_f_first: stb=%b we=%b adr=%h expected 1 1 0100", wb_stb_o, wb_we_o, wb_adr_o);
    end
    @(negedge clk);
    checks++;
    if ({f_ack, g_ack, wb_stb_o} !== 3'b100) begin
      errors++; $display("FAIL sim_gap: f_ack=%b g_ack=%b stb=%b expected 1 0 0", f_ack, g_ack, wb_stb_o);
    end
    @(negedge clk);
    checks++;
    if ({wb_stb_o, wb_we_o, wb_adr_o, f_ack, g_ack} !== {2'b10, 16'h0200, 2'b10}) begin
      errors++;
      $display("FAIL sim_g_second: stb=%b we=%b adr=%h f_ack=%b g_ack=%b expected 1 0 0200 1 0",
               wb_stb_o, wb_we_o, wb_adr_o, f_ack, g_ack);
    end
    @(negedge clk);
    checks++;
    if ({f_ack, g_ack} !== 2'b11 || g_dti !== 16'hABCD) begin
      errors++; $display("FAIL sim_both_ack: f=%b g=%b dti=%h expected 1 1 abcd", f_ack, g_ack, g_dti);
    end
    @(negedge clk);
    checks++;
    if ({f_ack, g_ack} !== 2'b00) begin
      errors++; $display("FAIL sim_ack_drop: f=%b g=%b expected 0 0", f_ack, g_ack);
    end
    // Withdrawing strobes while a fresh F cycle is in flight: it completes, no ack.
    tick();
    f_stb = 1'b0; g_stb = 1'b0; f_wre = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 16'h0100) begin
      errors++; $display("FAIL sim_inflight: stb=%b adr=%h expected 1 0100", wb_stb_o, wb_adr_o);
    end
    @(negedge clk);
    checks++;
    if ({f_ack, g_ack, wb_stb_o} !== 3'b000) begin
      errors++; $display("FAIL sim_discard: f=%b g=%b stb=%b expected 0 0 0", f_ack, g_ack, wb_stb_o);
    end
    $display("txn simultaneous f_write 0100 g_read 0200 dti=%h", g_dti);
  endtask

  task automatic test_back_to_back();
    slave_wait = 0;
    preload(16'h0002, 16'h1111);
    preload(16'h0003, 16'h2222);
    tick();
    g_adr = 16'h0002; g_stb = 1'b1; g_wre = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (g_ack !== 1'b1 || g_dti !== 16'h1111) begin
      errors++; $display("FAIL b2b_first: ack=%b dti=%h expected 1 1111", g_ack, g_dti);
    end
    tick();
    g_adr = 16'h0003;
    @(negedge clk);
    checks++;
    if (g_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_stale_ack: ack=%b expected 0", g_ack);
    end
    @(negedge clk);
    checks++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 16'h0003) begin
      errors++; $display("FAIL b2b_second_bus: stb=%b adr=%h expected 1 0003", wb_stb_o, wb_adr_o);
    end
    @(negedge clk);
    checks++;
    if (g_ack !== 1'b1 || g_dti !== 16'h2222) begin
      errors++; $display("FAIL b2b_second: ack=%b dti=%h expected 1 2222", g_ack, g_dti);
    end
    tick();
    g_stb = 1'b0;
    $display("txn back_to_back g_read 0002 then 0003 dti=%h", g_dti);
  endtask

  task automatic test_reset_mid();
    logic [69:0] outs;
    slave_wait = 5;
    tick();
    g_adr = 16'h0010; g_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wb_stb_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: stb=%b expected 1", wb_stb_o);
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    outs = {wb_stb_o, wb_cyc_o, wb_we_o, wb_err_o, g_ack, f_ack, wb_adr_o, wb_dat_o, g_dti, f_dti};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h expected 0", outs);
    end
    g_stb = 1'b0;
    tick();
    rst = 1'b0;
    $display("txn reset_mid_cycle");
  endtask

`ifdef DCPU16_BUSARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    slave_wait = 0;
    slave_noack = 1'b1;
    tick();
    g_adr = 16'h0004; g_stb = 1'b1; g_wre = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (wb_err_o === 1'b1) break;
    end
    checks++;
    if (wb_err_o !== 1'b1 || g_ack !== 1'b1 || g_dti !== 16'h0000 || n > 20) begin
      errors++;
      $display("FAIL timeout: err=%b ack=%b dti=%h cycles=%0d expected 1 1 0000 <=20", wb_err_o, g_ack, g_dti, n);
    end
    @(negedge clk);
    checks++;
    if (wb_err_o !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: err=%b expected 0", wb_err_o);
    end
    tick();
    g_stb = 1'b0;
    slave_noack = 1'b0;
    tick(); tick();
    $display("txn timeout cycles=%0d", n);
  endtask
`endif

  task automatic test_random();
    logic        fe, ge, fw, gw, ok;
    logic [15:0] fa, ga, fd, exp_f, exp_g;
    int          start, nexp, cyc, idx;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'($urandom);
      preload(16'(i), ref_mem[i]);
    end
    for (int t = 0; t < 150; t++) begin
      slave_wait = $urandom_range(0, 3);
      fe = 1'($urandom); ge = 1'($urandom);
      if (!fe && !ge) ge = 1'b1;
      fa = 16'($urandom_range(0, 15)); ga = 16'($urandom_range(0, 15));
      fw = 1'($urandom); gw = ($urandom_range(0, 7) == 0);
      fd = 16'($urandom);
      exp_f = '0; exp_g = '0;
      if (fe) begin
        if (fw) ref_mem[fa[3:0]] = fd;
        else exp_f = ref_mem[fa[3:0]];
      end
      if (ge) begin
        if (gw) ref_mem[ga[3:0]] = 16'h0000;
        else exp_g = ref_mem[ga[3:0]];
      end
      start = mon_cnt;
      nexp  = int'(fe) + int'(ge);
      f_adr = fa; f_wre = fw; f_dto = fd; f_stb = fe;
      g_adr = ga; g_wre = gw; g_stb = ge;
      ok = 1'b0;
      for (cyc = 0; cyc < 60; cyc++) begin
        @(negedge clk);
        if ((!fe || f_ack) && (!ge || g_ack)) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rnd_timeout group %0d: f_ack=%b g_ack=%b expected acks within 60 cycles", t, f_ack, g_ack);
        idle_inputs();
        return;
      end
      if (fe && !fw) begin
        checks++;
        if (f_dti !== exp_f) begin
          errors++; $display("FAIL rnd_f_data group %0d: got %h expected %h", t, f_dti, exp_f);
        end
      end
      if (ge && !gw) begin
        checks++;
        if (g_dti !== exp_g) begin
          errors++; $display("FAIL rnd_g_data group %0d: got %h expected %h", t, g_dti, exp_g);
        end
      end
      checks++;
      if (mon_cnt - start !== nexp) begin
        errors++; $display("FAIL rnd_txn_count group %0d: got %0d expected %0d", t, mon_cnt - start, nexp);
      end else begin
        idx = start % 64;
        if (fe) begin
          checks++;
          if (mon_adr[idx] !== fa || mon_we[idx] !== fw || (fw && mon_dat[idx] !== fd)) begin
            errors++;
            $display("FAIL rnd_f_bus group %0d: adr=%h we=%b dat=%h expected %h %b %h",
                     t, mon_adr[idx], mon_we[idx], mon_dat[idx], fa, fw, fd);
          end
          idx = (start + 1) % 64;
        end
        if (ge) begin
          checks++;
          if (mon_adr[idx] !== ga || mon_we[idx] !== gw || (gw && mon_dat[idx] !== 16'h0000)) begin
            errors++;
            $display("FAIL rnd_g_bus group %0d: adr=%h we=%b dat=%h expected %h %b 0000",
                     t, mon_adr[idx], mon_we[idx], mon_dat[idx], ga, gw);
          end
        end
      end
      $display("txn rnd %0d f=%b%s %h g=%b%s %h wait=%0d f_dti=%h g_dti=%h", t, fe, fw ? "W" : "R", fa,
               ge, gw ? "W" : "R", ga, slave_wait, f_dti, g_dti);
      tick();
      idle_inputs();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_g_read();
    test_f_write();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
`ifdef DCPU16_BUSARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
